// File: rtl/seg7_capture_pkg.sv
// Shared definitions for the 7-segment display path: segment table, digit count
// and the capture FSM states.
package seg7_capture_pkg;

   localparam int NUM_DIGITS = 4;

   // Segment order a..g maps to bits 6..0; index is the hex value shown.
   localparam logic [6:0] SEG_TABLE [0:15] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   // Synchronized sample layout {seg[6:0], dp, line[3:0]} and its idle value.
   localparam logic [11:0] SMP_RST = {7'b0000000, 1'b0, 4'b1111};

   typedef enum logic [1:0] {
      ST_WAIT    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } cap_state_t;

endpackage

// File: rtl/seg7_pattern_to_hex.sv
// Combinational inverse of the segment table: a segment pattern to its hex
// nibble, with hit low when the pattern is not a table entry.
module seg7_pattern_to_hex
   import seg7_capture_pkg::*;
(
   input  logic [6:0] seg,
   output logic       hit,
   output logic [3:0] nibble
);

   always_comb begin
      hit    = 1'b0;
      nibble = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (seg == SEG_TABLE[i]) begin
            hit    = 1'b1;
            nibble = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seg7_capture.sv
// Reconstructs the four hex digits shown on a multiplexed 7-segment bus,
// accepting each pattern only after it has held stable.
module seg7_capture
   import seg7_capture_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT       = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg,
   input  logic        dp,
   input  logic [3:0]  line,
   output logic [15:0] digits,
   output logic [3:0]  dp_out,
   output logic [3:0]  digit_valid,
   output logic        pattern_err,
   output logic        select_err,
   output logic        frame_done
);

   localparam int          TW          = $clog2(TIMEOUT + 1);
   localparam logic [7:0]  CNT_MAX     = 8'(STABLE_CYCLES);
   localparam logic [7:0]  CNT_LAST    = 8'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

   logic [11:0]      sync_p0, sync_p1, prev_p2;
   logic [7:0]       cnt;
   logic             change;
   cap_state_t       state, state_nxt;

   logic [3:0]       lows;
   logic             single;
   logic             hit;
   logic [3:0]       nibble;
   logic             do_capture;
   logic [3:0]       cap_hot;
   logic             perr_nxt, serr_nxt;
   logic [3:0]       mask, mask_set;
   logic [TW-1:0]    tcnt [NUM_DIGITS];

   // Stage p0/p1: two-flop synchronizer; p2: previous sample for change detect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= SMP_RST;
         sync_p1 <= SMP_RST;
         prev_p2 <= SMP_RST;
         cnt     <= 8'd0;
      end else begin
         sync_p0 <= {seg, dp, line};
         sync_p1 <= sync_p0;
         prev_p2 <= sync_p1;
         if (change)
            cnt <= 8'd0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 8'd1;
      end
   end

   assign change = (sync_p1 != prev_p2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_WAIT;
      else
         state <= state_nxt;
   end

   // A change seen while capturing starts a new window at once so it is not lost.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_WAIT:    if (change) state_nxt = ST_SETTLE;
         ST_SETTLE:  if (!change && cnt == CNT_LAST) state_nxt = ST_CAPTURE;
         ST_CAPTURE: state_nxt = change ? ST_SETTLE : ST_HOLD;
         ST_HOLD:    if (change) state_nxt = ST_SETTLE;
         default:    state_nxt = ST_WAIT;
      endcase
   end

   // The capture uses prev_p2, which still holds the value of the stable window.
   seg7_pattern_to_hex u_dec (
      .seg    (prev_p2[11:5]),
      .hit    (hit),
      .nibble (nibble)
   );

   always_comb begin
      do_capture = (state == ST_CAPTURE);
      lows       = ~prev_p2[3:0];
      single     = (lows != 4'b0000) && ((lows & (lows - 4'd1)) == 4'b0000);
      cap_hot    = (do_capture && single && hit) ? lows : 4'b0000;
      perr_nxt   = do_capture && single && !hit;
      serr_nxt   = do_capture && !single && (lows != 4'b0000);
      mask_set   = mask | cap_hot;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits      <= 16'h0000;
         dp_out      <= 4'b0000;
         mask        <= 4'b0000;
         pattern_err <= 1'b0;
         select_err  <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         pattern_err <= perr_nxt;
         select_err  <= serr_nxt;
         frame_done  <= (mask_set == 4'b1111);
         mask        <= (mask_set == 4'b1111) ? 4'b0000 : mask_set;
         for (int n = 0; n < NUM_DIGITS; n++) begin
            if (cap_hot[n]) begin
               digits[4*n +: 4] <= nibble;
               dp_out[n]        <= prev_p2[4];
            end
         end
      end
   end

   // Per-digit freshness: a capture on the expiry cycle takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_valid <= 4'b0000;
         for (int n = 0; n < NUM_DIGITS; n++)
            tcnt[n] <= '0;
      end else begin
         for (int n = 0; n < NUM_DIGITS; n++) begin
            if (cap_hot[n]) begin
               tcnt[n]        <= '0;
               digit_valid[n] <= 1'b1;
            end else if (tcnt[n] == TMO_LAST) begin
               tcnt[n]        <= TMO_MAX;
               digit_valid[n] <= 1'b0;
            end else if (tcnt[n] != TMO_MAX) begin
               tcnt[n] <= tcnt[n] + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Receive-side counterpart of the team's 7-segment display path.
- Monitors a multiplexed 7-segment display bus (segment lines plus active-low digit selects) and reconstructs the four hex digits being shown.
- Each pattern is accepted only after it holds stable, then decoded back to a nibble; freshness is tracked per digit.
- Sits on the test/readback side of the board, e.g. for self-check of display firmware or a logic-analyser feed.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a capture; legal range 2..255.
- TIMEOUT, 1000000: cycles without a refresh before a digit's valid bit clears; minimum 16.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg  in  7  segment levels, active-high, bit6=a … bit0=g
- dp  in  1  decimal point, active-high; captured only
- line  in  4  digit selects, active-low, bit n selects digit n
- digits  out  16  captured nibbles, digit n at [4n+3:4n]
- dp_out  out  4  captured dp per digit
- digit_valid  out  4  digit n captured within the last TIMEOUT cycles
- pattern_err  out  1  one-cycle pulse: stable pattern not in the hex table
- select_err  out  1  one-cycle pulse: stable line with more than one bit low
- frame_done  out  1  one-cycle pulse: all four digits captured since the previous pulse or since reset

Behaviour:
- Reset (async assert, sync release): digits=0, dp_out=0, digit_valid=0, pulses=0, FSM=WAIT, counters=0, synchronizer flops=1 for line and 0 for seg/dp.
- Inputs {seg,dp,line} pass through a 2-flop synchronizer; all logic below uses synchronized values.
- Stability counter cnt, 8 bits, saturating at STABLE_CYCLES:
  - sample differs from previous sample -> cnt=0;
  - otherwise cnt increments.
- FSM states:
  - WAIT -> SETTLE on any sample change.
  - SETTLE -> CAPTURE when cnt reaches STABLE_CYCLES-1 with no change; SETTLE -> SETTLE (cnt=0) on a change.
  - CAPTURE lasts one cycle and performs the capture action, then -> HOLD.
  - HOLD -> SETTLE on a change.
  - Exactly one capture per stable window.
- Capture action by line value:
  - Exactly one bit low (index n): decode seg via the inverse of the team's table. 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
    - Match: digits[n]<=value, dp_out[n]<=dp, digit_valid[n]<=1, timeout counter n reset, captured-mask bit n set.
    - No match: pattern_err pulses; digits[n], digit_valid[n] and mask unchanged.
  - line=1111 (blanking): no action, no error.
  - Two or more bits low: select_err pulses; nothing else changes.
- frame_done pulses on the cycle after the capture that completes the mask; the mask clears on that same cycle. The completing capture's update and the mask clear are atomic.
- Latency: with inputs constant from clock edge 0, outputs reflect the new digit after exactly STABLE_CYCLES+3 edges.
- Timeout counters:
  - Four per-digit counters saturating at TIMEOUT.
  - Reaching TIMEOUT clears digit_valid[n]; digits[n] is retained.
  - If a capture on digit n and a timeout on digit n fall in the same cycle, the capture wins.
- Mid-operation reset: immediate return to the reset state; the next capture needs a full fresh stable window.

Decomposition:
- Shared package holds:
  - the 16 segment-pattern constants (shared with the forward decoder so both directions use one table);
  - the digit-count constant 4;
  - the FSM state enum.
- One sub-module is natural: seg7_pattern_to_hex, purely combinational: seg[6:0] -> {hit, nibble[3:0]}.

Test Plan:
- Reset: drive seg=1111001, line=1110, hold rst_n low 5 cycles -> all outputs 0; after release, digits[3:0]=3 and digit_valid=0001 exactly 7 edges later (STABLE_CYCLES=4).
- Full frame: cycle digits 0..3 with patterns A, b, C, d, 10 cycles each -> digits=16'hDCBA, digit_valid=1111, frame_done pulses once after the digit 3 capture.
- Glitch rejection: toggle seg between 1111110 and 0110000 every 2 cycles on line=1101 -> no capture, digits unchanged; then hold 0110000 -> digits[7:4]=1.
- Errors:
  - seg=0000001 stable on line=1011 -> single pattern_err pulse, digit 2 unchanged;
  - line=1001 stable -> single select_err pulse;
  - line=1111 -> no pulses.
- Timeout: TIMEOUT=16; capture digit 0, then blank -> digit_valid[0] clears 16 cycles after capture, digits[3:0] retained; recapture on the exact timeout cycle keeps valid=1.
